irrigation_countdown: RTL
=========================

// Module: irrigation_countdown
// PURPOSE
//  Countdown side of the irrigation timer. Loads an M:MS:S preset (BCD MM:S0, seconds-units forced to 0)
//  on the load strobe from the timer reset logic, decrements once per second while irrigation is on,
//  and drives the minutes_d/minutes_u/seconds_d digits back to the reset logic and the display.
//  Range 00:00..39:59 (2-bit tens of minutes). Presets in use: sprinkler 15:00, dripper 30:00.
// PARAMETERS
//  CLK_HZ      50_000_000  input clock frequency; prescaler divides to a 1 Hz tick
//  TICK_DIV    CLK_HZ      clocks per tick (override small for simulation); must be >= 2
// PORTS
//  clk                input   1  system clock
//  rst                input   1  asynchronous, active-high reset
//  load               input   1  level; while high, digits <= presets, prescaler cleared
//  minutes_d_preset   input   2  tens-of-minutes preset (0..3)
//  minutes_u_preset   input   4  units-of-minutes preset, BCD (0..9)
//  seconds_d_preset   input   3  tens-of-seconds preset (0..5)
//  irrigation_on      input   1  count enable
//  minutes_d          output  2  tens of minutes
//  minutes_u          output  4  units of minutes, BCD
//  seconds_d          output  3  tens of seconds
//  seconds_u          output  4  units of seconds, BCD
//  running            output  1  state == RUN
//  expired            output  1  1-clk pulse on the decrement that reaches 00:00
// BEHAVIOUR
//  Reset: all digits 0, prescaler 0, state IDLE, running=0, expired=0.
//  States: IDLE (digits == 0, not counting), RUN, HOLD (nonzero, irrigation_on=0).
//   - load=1 (any state): digits <= {preset,0}; next state RUN if irrigation_on & preset!=0,
//     HOLD if preset!=0 & !irrigation_on, IDLE if preset==0. load has priority over tick.
//   - RUN -> HOLD when irrigation_on=0; HOLD -> RUN when irrigation_on=1. Prescaler frozen in HOLD.
//   - RUN and tick: decrement by one second; if result == 00:00 -> IDLE, pulse expired that cycle.
//  Prescaler: counts 0..TICK_DIV-1 in RUN only; tick = (count == TICK_DIV-1); first tick after
//   load/resume arrives exactly TICK_DIV clocks later (latency 1 s, never a partial first second).
//  Decrement: seconds_u 0->9 borrows seconds_d; seconds_d 0->5 borrows minutes_u; minutes_u 0->9
//   borrows minutes_d. Never wraps below 00:00; IDLE ignores ticks.
//  Invalid presets: minutes_u_preset > 9 loads 9; seconds_d_preset > 5 loads 5 (saturate).
//  Outputs are registered; digit change is visible the clock after tick.
//  expired never asserts on load of a zero preset nor on reset.
// CONFIGURATION
//  TIMER_PAUSE_EN defined: adds input `pause` (1 bit); pause=1 freezes digits and prescaler in RUN
//   (running stays 1, no tick, no expired); load still overrides pause.
//  TIMER_PAUSE_EN undefined: no `pause` port; counting governed only by irrigation_on and load.
// TESTING (TICK_DIV=4)
//  load 15:00, irrigation_on=1 -> 14:59 after 4 clks; 00:00 after 900 ticks, expired 1 clk, IDLE
//  load 00:10, after 9 ticks -> 00:01; next tick 00:00 + expired; further ticks keep 00:00, no pulse
//  load 30:00, run 2 clks, irrigation_on=0 for 20 clks, re-enable -> 29:59 exactly 4 RUN clks total
//  load 10:00 -> 09:59 on first tick (multi-digit borrow); load minutes_u_preset=12 -> 9 loaded
//  rst asserted mid-count (at 14:37) -> outputs 00:00 async, running=0; load+tick same clk -> preset wins
//  TIMER_PAUSE_EN: pause=1 for 10 clks mid-count -> digits unchanged, running=1, resume continues

Source files
------------

// File: rtl/irrigation_countdown_if.sv
// irrigation_countdown_if: preset/enable inputs and digit/status outputs of the irrigation countdown.
// Carries the optional `pause` line when TIMER_PAUSE_EN is defined.
interface irrigation_countdown_if;
  logic       load;
  logic [1:0] minutes_d_preset;
  logic [3:0] minutes_u_preset;
  logic [2:0] seconds_d_preset;
  logic       irrigation_on;
`ifdef TIMER_PAUSE_EN
  logic       pause;
`endif
  logic [1:0] minutes_d;
  logic [3:0] minutes_u;
  logic [2:0] seconds_d;
  logic [3:0] seconds_u;
  logic       running;
  logic       expired;
  modport master (
`ifdef TIMER_PAUSE_EN
    output pause,
`endif
    output load, minutes_d_preset, minutes_u_preset, seconds_d_preset, irrigation_on,
    input  minutes_d, minutes_u, seconds_d, seconds_u, running, expired
  );
  modport slave (
`ifdef TIMER_PAUSE_EN
    input  pause,
`endif
    input  load, minutes_d_preset, minutes_u_preset, seconds_d_preset, irrigation_on,
    output minutes_d, minutes_u, seconds_d, seconds_u, running, expired
  );
endinterface

// File: rtl/irrigation_countdown.sv
// irrigation_countdown: loads an MM:S0 preset and counts down once per prescaled tick to 00:00.
// TIMER_PAUSE_EN adds a pause input that freezes digits and prescaler while running.
module irrigation_countdown #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_DIV = CLK_HZ
) (
  input logic                  clk,
  input logic                  rst,
  irrigation_countdown_if.slave bus
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [1:0] md, n_md;
  logic [3:0] mu, n_mu, su, n_su, mu_p;
  logic [2:0] sd, n_sd, sd_p;
  logic ex, paused, pre_nz, count_en, tick, last;
`ifdef TIMER_PAUSE_EN
  assign paused = bus.pause;
`else
  assign paused = 1'b0;
`endif
  always_comb begin
    mu_p = bus.minutes_u_preset > 4'd9 ? 4'd9 : bus.minutes_u_preset;
    sd_p = bus.seconds_d_preset > 3'd5 ? 3'd5 : bus.seconds_d_preset;
    pre_nz = |{bus.minutes_d_preset, mu_p, sd_p};
    count_en = state == RUN && bus.irrigation_on && !paused;
    tick = count_en && cnt == CW'(TICK_DIV - 1);
    n_su = su == 4'd0 ? 4'd9 : su - 4'd1;
    n_sd = su != 4'd0 ? sd : sd == 3'd0 ? 3'd5 : sd - 3'd1;
    n_mu = (su != 4'd0 || sd != 3'd0) ? mu : mu == 4'd0 ? 4'd9 : mu - 4'd1;
    n_md = (su != 4'd0 || sd != 3'd0 || mu != 4'd0) ? md : md - 2'd1;
    last = ~|{md, mu, sd} && su == 4'd1;
  end
  // load wins over everything; an enable change costs one clock before counting resumes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      md    <= '0;
      mu    <= '0;
      sd    <= '0;
      su    <= '0;
      ex    <= 1'b0;
    end else begin
      ex <= 1'b0;
      if (bus.load) begin
        md    <= bus.minutes_d_preset;
        mu    <= mu_p;
        sd    <= sd_p;
        su    <= 4'd0;
        cnt   <= '0;
        state <= !pre_nz ? IDLE : bus.irrigation_on ? RUN : HOLD;
      end else if (state == RUN && !bus.irrigation_on) begin
        state <= HOLD;
      end else if (state == HOLD && bus.irrigation_on) begin
        state <= RUN;
      end else if (count_en) begin
        cnt <= tick ? '0 : cnt + 1'b1;
        if (tick) begin
          md <= n_md;
          mu <= n_mu;
          sd <= n_sd;
          su <= n_su;
          if (last) begin
            state <= IDLE;
            ex    <= 1'b1;
          end
        end
      end
    end
  end
  assign bus.minutes_d = md;
  assign bus.minutes_u = mu;
  assign bus.seconds_d = sd;
  assign bus.seconds_u = su;
  assign bus.running   = state == RUN;
  assign bus.expired   = ex;
endmodule
